// File: rtl/rv_imm_pkg.sv
// rv_imm_pkg
//   Shared definitions for the instruction encoder/loader: immediate-source
//   selects (same encoding as the core's ImmSrc decode), error codes,
//   immediate range limits, loader FSM states and the registered request
//   record.
package rv_imm_pkg;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;
    localparam logic [2:0] IMM_R = 3'b111;

    localparam logic [2:0] ERR_NONE     = 3'd0;
    localparam logic [2:0] ERR_RANGE    = 3'd1;
    localparam logic [2:0] ERR_MISALIGN = 3'd2;
    localparam logic [2:0] ERR_SRC      = 3'd3;

    // Signed limits of the encodable immediate for each format. B/J maxima are
    // even because bit 0 is implied zero.
    localparam int IS_MIN = -2048;
    localparam int IS_MAX = 2047;
    localparam int B_MIN  = -4096;
    localparam int B_MAX  = 4094;
    localparam int J_MIN  = -1048576;
    localparam int J_MAX  = 1048574;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ENCODE,
        ST_WRITE
    } state_e;

    typedef struct packed {
        logic [2:0]  imm_src;
        logic [6:0]  opcode;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
    } req_fields_t;

endpackage

// File: rtl/instr_encoder_loader_if.sv
// instr_encoder_loader_if
//   Request channel of the loader: valid/ready handshake plus the instruction
//   fields to encode.
//   master: drives req_valid and all req_* fields, samples req_ready
//   slave : samples req_valid and fields, drives req_ready
interface instr_encoder_loader_if;

    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_imm_src;
    logic [6:0]  req_opcode;
    logic [2:0]  req_funct3;
    logic [6:0]  req_funct7;
    logic [4:0]  req_rd;
    logic [4:0]  req_rs1;
    logic [4:0]  req_rs2;
    logic [31:0] req_imm;

    modport master (
        output req_valid, req_imm_src, req_opcode, req_funct3, req_funct7,
               req_rd, req_rs1, req_rs2, req_imm,
        input  req_ready
    );

    modport slave (
        input  req_valid, req_imm_src, req_opcode, req_funct3, req_funct7,
               req_rd, req_rs1, req_rs2, req_imm,
        output req_ready
    );

endinterface

// File: rtl/imm_scatter.sv
// imm_scatter
//   Combinational encoder: places register/function fields and scatters the
//   immediate into RISC-V bit positions for the selected format, and reports
//   why the immediate cannot be encoded.
//   in : imm_src, imm, opcode, funct3, funct7, rd, rs1, rs2
//   out: word (encoded instruction), err_code (ERR_NONE when encodable)
module imm_scatter
    import rv_imm_pkg::*;
(
    input  logic [2:0]  imm_src,
    input  logic [31:0] imm,
    input  logic [6:0]  opcode,
    input  logic [2:0]  funct3,
    input  logic [6:0]  funct7,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    output logic [31:0] word,
    output logic [2:0]  err_code
);

    logic signed [31:0] imm_s;
    assign imm_s = $signed(imm);

    always_comb begin
        word      = '0;
        err_code  = ERR_NONE;
        word[6:0] = opcode;
        case (imm_src)
            IMM_I: begin
                word[11:7]  = rd;
                word[14:12] = funct3;
                word[19:15] = rs1;
                word[31:20] = imm[11:0];
                if (imm_s < IS_MIN || imm_s > IS_MAX) err_code = ERR_RANGE;
            end
            IMM_S: begin
                word[11:7]  = imm[4:0];
                word[14:12] = funct3;
                word[19:15] = rs1;
                word[24:20] = rs2;
                word[31:25] = imm[11:5];
                if (imm_s < IS_MIN || imm_s > IS_MAX) err_code = ERR_RANGE;
            end
            IMM_B: begin
                word[7]     = imm[11];
                word[11:8]  = imm[4:1];
                word[14:12] = funct3;
                word[19:15] = rs1;
                word[24:20] = rs2;
                word[30:25] = imm[10:5];
                word[31]    = imm[12];
                // Range wins over alignment when both are wrong.
                if (imm_s < B_MIN || imm_s > B_MAX) err_code = ERR_RANGE;
                else if (imm[0])                    err_code = ERR_MISALIGN;
            end
            IMM_J: begin
                word[11:7]  = rd;
                word[19:12] = imm[19:12];
                word[20]    = imm[11];
                word[30:21] = imm[10:1];
                word[31]    = imm[20];
                if (imm_s < J_MIN || imm_s > J_MAX) err_code = ERR_RANGE;
                else if (imm[0])                    err_code = ERR_MISALIGN;
            end
            IMM_U: begin
                word[11:7]  = rd;
                word[31:12] = imm[31:12];
                // Low 12 bits are not representable in a U immediate.
                if (imm[11:0] != 12'h000) err_code = ERR_MISALIGN;
            end
            IMM_R: begin
                word[11:7]  = rd;
                word[14:12] = funct3;
                word[19:15] = rs1;
                word[24:20] = rs2;
                word[31:25] = funct7;
            end
            default: begin
                err_code = ERR_SRC;
            end
        endcase
    end

endmodule

// File: rtl/instr_encoder_loader.sv
// instr_encoder_loader
//   Boot/test-program loader: accepts instruction field requests, encodes
//   them and writes the words sequentially into instruction memory
//   (IDLE -> ENCODE -> WRITE, one word per three cycles).
//   clk, reset : clock and synchronous active-high reset
//   start      : one-cycle pulse clearing count/err and dropping any request
//   req        : request channel (slave side)
//   mem_we/mem_addr/mem_wdata : instruction memory write port
//   count/full : words written, full at DEPTH
//   err/err_code : sticky rejection flag and last rejection reason
module instr_encoder_loader
    import rv_imm_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0,
    parameter int          DEPTH     = 64,
    parameter int          ADDR_W    = 32,
    localparam int         CNT_W     = $clog2(DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    instr_encoder_loader_if.slave req,
    output logic                 mem_we,
    output logic [ADDR_W-1:0]    mem_addr,
    output logic [31:0]          mem_wdata,
    output logic [CNT_W-1:0]     count,
    output logic                 full,
    output logic                 err,
    output logic [2:0]           err_code
);

    state_e             state_q, state_d;
    req_fields_t        fld_q, fld_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               err_q, err_d;
    logic [2:0]         err_code_q, err_code_d;

    logic [31:0]        enc_word;
    logic [2:0]         enc_err;
    logic               req_fire;

    imm_scatter u_imm_scatter (
        .imm_src  (fld_q.imm_src),
        .imm      (fld_q.imm),
        .opcode   (fld_q.opcode),
        .funct3   (fld_q.funct3),
        .funct7   (fld_q.funct7),
        .rd       (fld_q.rd),
        .rs1      (fld_q.rs1),
        .rs2      (fld_q.rs2),
        .word     (enc_word),
        .err_code (enc_err)
    );

    assign full     = (count_q == CNT_W'(DEPTH));
    assign req_fire = req.req_valid && req.req_ready;

    // State register
    always_ff @(posedge clk) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic; start overrides everything.
    always_comb begin
        state_d = state_q;
        if (start) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:   if (req_fire) state_d = ST_ENCODE;
                ST_ENCODE: state_d = (enc_err != ERR_NONE) ? ST_IDLE : ST_WRITE;
                ST_WRITE:  state_d = ST_IDLE;
                default:   state_d = ST_IDLE;
            endcase
        end
    end

    // Outputs; start suppresses both acceptance and an in-flight write.
    always_comb begin
        req.req_ready = (state_q == ST_IDLE) && !full && !start && !reset;
        mem_we        = (state_q == ST_WRITE) && !start;
    end

    always_comb begin
        fld_d      = fld_q;
        wdata_d    = wdata_q;
        count_d    = count_q;
        err_d      = err_q;
        err_code_d = err_code_q;
        if (start) begin
            count_d    = '0;
            err_d      = 1'b0;
            err_code_d = ERR_NONE;
        end else begin
            if (req_fire) begin
                fld_d.imm_src = req.req_imm_src;
                fld_d.opcode  = req.req_opcode;
                fld_d.funct3  = req.req_funct3;
                fld_d.funct7  = req.req_funct7;
                fld_d.rd      = req.req_rd;
                fld_d.rs1     = req.req_rs1;
                fld_d.rs2     = req.req_rs2;
                fld_d.imm     = req.req_imm;
            end
            if (state_q == ST_ENCODE) begin
                if (enc_err != ERR_NONE) begin
                    err_d      = 1'b1;
                    err_code_d = enc_err;
                end else begin
                    wdata_d = enc_word;
                end
            end
            if (state_q == ST_WRITE) count_d = count_q + CNT_W'(1);
        end
    end

    // Request fields are pure data and only meaningful after a transfer.
    always_ff @(posedge clk) begin
        fld_q <= fld_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wdata_q    <= '0;
            count_q    <= '0;
            err_q      <= 1'b0;
            err_code_q <= ERR_NONE;
        end else begin
            wdata_q    <= wdata_d;
            count_q    <= count_d;
            err_q      <= err_d;
            err_code_q <= err_code_d;
        end
    end

    // Address tracks the count, so it is already correct for the next word.
    assign mem_addr  = ADDR_W'(BASE_ADDR) + (ADDR_W'(count_q) << 2);
    assign mem_wdata = wdata_q;
    assign count     = count_q;
    assign err       = err_q;
    assign err_code  = err_code_q;

endmodule

// File: tb/tb_instr_encoder_loader.sv
module tb_instr_encoder_loader;

    localparam int DEPTH = 4;
    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef struct {
        logic [2:0]  src;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
    } req_t;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic             mem_we;
    logic [31:0]      mem_addr;
    logic [31:0]      mem_wdata;
    logic [CNT_W-1:0] count;
    logic             full;
    logic             err;
    logic [2:0]       err_code;

    instr_encoder_loader_if rif ();

    instr_encoder_loader #(
        .BASE_ADDR (32'h0),
        .DEPTH     (DEPTH),
        .ADDR_W    (32)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .req       (rif),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .count     (count),
        .full      (full),
        .err       (err),
        .err_code  (err_code)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference state
    int          m_count = 0;
    logic        m_err = 1'b0;
    logic [2:0]  m_err_code = 3'd0;
    int          exp_writes = 0;
    int          we_seen = 0;
    logic [31:0] last_wdata;
    logic [31:0] last_addr;

    always @(negedge clk) if (mem_we) we_seen++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Spec-level encoding: instruction layout and immediate rules written
    // directly as concatenations and integer range tests.
    task automatic model_enc(input req_t r, output logic [31:0] w, output logic [2:0] code);
        int s;
        s    = $signed(r.imm);
        w    = 32'h0;
        code = 3'd0;
        case (r.src)
            3'b000: begin
                w = {r.imm[11:0], r.rs1, r.f3, r.rd, r.op};
                if (s < -2048 || s > 2047) code = 3'd1;
            end
            3'b001: begin
                w = {r.imm[11:5], r.rs2, r.rs1, r.f3, r.imm[4:0], r.op};
                if (s < -2048 || s > 2047) code = 3'd1;
            end
            3'b010: begin
                w = {r.imm[12], r.imm[10:5], r.rs2, r.rs1, r.f3, r.imm[4:1], r.imm[11], r.op};
                if (s < -4096 || s > 4094) code = 3'd1;
                else if (s % 2 != 0)       code = 3'd2;
            end
            3'b011: begin
                w = {r.imm[20], r.imm[10:1], r.imm[11], r.imm[19:12], r.rd, r.op};
                if (s < -1048576 || s > 1048574) code = 3'd1;
                else if (s % 2 != 0)             code = 3'd2;
            end
            3'b100: begin
                w = {r.imm[31:12], r.rd, r.op};
                if ((r.imm % 4096) != 0) code = 3'd2;
            end
            3'b111: w = {r.f7, r.rs2, r.rs1, r.f3, r.rd, r.op};
            default: code = 3'd3;
        endcase
    endtask

    task automatic drive(input req_t r, input logic v);
        rif.req_valid   = v;
        rif.req_imm_src = r.src;
        rif.req_opcode  = r.op;
        rif.req_funct3  = r.f3;
        rif.req_funct7  = r.f7;
        rif.req_rd      = r.rd;
        rif.req_rs1     = r.rs1;
        rif.req_rs2     = r.rs2;
        rif.req_imm     = r.imm;
    endtask

    task automatic xfer(input req_t r);
        logic [31:0] ew;
        logic [2:0]  ec;
        int          waited;
        model_enc(r, ew, ec);
        waited = 0;
        while (!rif.req_ready && waited < 20) begin
            tick();
            waited++;
        end
        if (!rif.req_ready) begin
            chk("ready_timeout", 32'(rif.req_ready), 32'd1);
            return;
        end
        drive(r, 1'b1);
        tick();                      // handshake edge
        rif.req_valid = 1'b0;
        chk("encode_we", 32'(mem_we), 32'd0);
        chk("encode_ready", 32'(rif.req_ready), 32'd0);
        tick();
        if (ec == 3'd0) begin
            chk("we", 32'(mem_we), 32'd1);
            chk("addr", mem_addr, 32'(m_count * 4));
            chk("wdata", mem_wdata, ew);
            last_wdata = mem_wdata;
            last_addr  = mem_addr;
            exp_writes++;
            tick();
            m_count++;
            chk("we_one_cycle", 32'(mem_we), 32'd0);
            chk("count", 32'(count), 32'(m_count));
            chk("err_sticky", 32'(err), 32'(m_err));
        end else begin
            m_err      = 1'b1;
            m_err_code = ec;
            chk("err_no_we", 32'(mem_we), 32'd0);
            chk("err", 32'(err), 32'd1);
            chk("err_code", 32'(err_code), 32'(ec));
            chk("err_count", 32'(count), 32'(m_count));
        end
        chk("full", 32'(full), 32'(m_count == DEPTH));
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        m_count    = 0;
        m_err      = 1'b0;
        m_err_code = 3'd0;
        chk("start_count", 32'(count), 32'd0);
        chk("start_err", 32'(err), 32'd0);
        chk("start_err_code", 32'(err_code), 32'd0);
        chk("start_we", 32'(mem_we), 32'd0);
    endtask

    function automatic req_t mk(input logic [2:0] src, input logic [6:0] op, input logic [2:0] f3,
                                input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic [31:0] imm);
        req_t r;
        r.src = src; r.op = op; r.f3 = f3; r.f7 = 7'd0;
        r.rd = rd; r.rs1 = rs1; r.rs2 = rs2; r.imm = imm;
        return r;
    endfunction

    int edge_imm[15] = '{2047, 2048, -2048, -2049, 4094, 4095, 4096, -4096, -4097,
                         1048574, 1048575, -1048576, -1048578, 3, 0};

    initial begin
        req_t r;
        reset = 1'b1;
        start = 1'b0;
        drive(mk(3'd0, 7'd0, 3'd0, 5'd0, 5'd0, 5'd0, 32'd0), 1'b0);
        tick();
        chk("rst_ready", 32'(rif.req_ready), 32'd0);
        tick();
        chk("rst_we", 32'(mem_we), 32'd0);
        chk("rst_addr", mem_addr, 32'd0);
        chk("rst_wdata", mem_wdata, 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_err_code", 32'(err_code), 32'd0);
        reset = 1'b0;
        #1;
        chk("post_rst_ready", 32'(rif.req_ready), 32'd1);

        // Directed encodings
        xfer(mk(3'b000, 7'b0010011, 3'b000, 5'd5, 5'd0, 5'd0, 32'hFFFFFFFF));
        chk("addi_word", last_wdata, 32'hFFF00293);
        chk("addi_addr", last_addr, 32'd0);
        pulse_start();
        xfer(mk(3'b010, 7'b1100011, 3'b000, 5'd0, 5'd1, 5'd2, 32'd8));
        chk("beq_word", last_wdata, 32'h00208463);
        chk("beq_addr", last_addr, 32'd0);
        xfer(mk(3'b011, 7'b1101111, 3'b000, 5'd1, 5'd0, 5'd0, 32'hFFFFFFFC));
        chk("jal_word", last_wdata, 32'hFFDFF0EF);
        chk("jal_addr", last_addr, 32'd4);
        xfer(mk(3'b000, 7'b0010011, 3'b000, 5'd1, 5'd0, 5'd0, 32'd2048));
        chk("range_code", 32'(err_code), 32'd1);
        chk("range_count", 32'(count), 32'd2);
        xfer(mk(3'b010, 7'b1100011, 3'b000, 5'd0, 5'd1, 5'd2, 32'd3));
        chk("misalign_code", 32'(err_code), 32'd2);
        xfer(mk(3'b100, 7'b0110111, 3'b000, 5'd10, 5'd0, 5'd0, 32'h12345000));
        chk("lui_word", last_wdata, 32'h12345537);
        chk("lui_addr", last_addr, 32'd8);
        chk("err_kept", 32'(err), 32'd1);
        xfer(mk(3'b101, 7'b0110011, 3'b000, 5'd1, 5'd1, 5'd1, 32'd0));
        chk("illegal_code", 32'(err_code), 32'd3);
        xfer(mk(3'b000, 7'b0010011, 3'b000, 5'd1, 5'd0, 5'd0, 32'd1));
        chk("fill_full", 32'(full), 32'd1);

        // Full: a pending request stalls and nothing is written
        r = mk(3'b000, 7'b0010011, 3'b000, 5'd1, 5'd0, 5'd0, 32'd7);
        drive(r, 1'b1);
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("full_ready", 32'(rif.req_ready), 32'd0);
        end
        chk("full_count", 32'(count), 32'd4);
        rif.req_valid = 1'b0;
        chk("full_writes", 32'(we_seen), 32'(exp_writes));
        pulse_start();
        xfer(r);
        chk("restart_addr", last_addr, 32'd0);

        // start together with req_valid in IDLE: no transfer
        drive(r, 1'b1);
        start = 1'b1;
        tick();
        start = 1'b0;
        rif.req_valid = 1'b0;
        m_count = 0; m_err = 1'b0; m_err_code = 3'd0;
        tick(); tick();
        chk("start_valid_count", 32'(count), 32'd0);
        chk("start_valid_writes", 32'(we_seen), 32'(exp_writes));

        // start during ENCODE drops the request
        drive(r, 1'b1);
        tick();
        rif.req_valid = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("abort_we", 32'(mem_we), 32'd0);
        tick();
        chk("abort_we2", 32'(mem_we), 32'd0);
        chk("abort_count", 32'(count), 32'd0);
        chk("abort_writes", 32'(we_seen), 32'(exp_writes));

        // Randomized requests against the reference model
        for (int n = 0; n < 60; n++) begin
            if (m_count == DEPTH) pulse_start();
            r.src = 3'($urandom_range(0, 7));
            r.op  = 7'($urandom);
            r.f3  = 3'($urandom);
            r.f7  = 7'($urandom);
            r.rd  = 5'($urandom);
            r.rs1 = 5'($urandom);
            r.rs2 = 5'($urandom);
            case ($urandom_range(0, 3))
                0: r.imm = 32'(edge_imm[$urandom_range(0, 14)]);
                1: r.imm = $urandom & 32'hFFFFF000;
                2: r.imm = 32'($signed(12'($urandom))) & 32'hFFFFFFFE;
                default: r.imm = $urandom;
            endcase
            xfer(r);
        end
        chk("random_writes", 32'(we_seen), 32'(exp_writes));

        // Reset during WRITE
        if (m_count == DEPTH) pulse_start();
        drive(mk(3'b111, 7'b0110011, 3'b000, 5'd3, 5'd4, 5'd5, 32'd0), 1'b1);
        tick();
        rif.req_valid = 1'b0;
        tick();
        chk("pre_rst_we", 32'(mem_we), 32'd1);
        exp_writes++;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        chk("wrst_we", 32'(mem_we), 32'd0);
        chk("wrst_count", 32'(count), 32'd0);
        chk("wrst_addr", mem_addr, 32'd0);
        chk("wrst_wdata", mem_wdata, 32'd0);
        chk("wrst_err", 32'(err), 32'd0);
        chk("wrst_err_code", 32'(err_code), 32'd0);
        chk("wrst_full", 32'(full), 32'd0);
        tick();
        chk("final_writes", 32'(we_seen), 32'(exp_writes));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
